// File: rtl/reset_pkg.sv
// +----------------------------------------------------------------------------+
// | reset_pkg: shared state encoding and synchronizer depth for reset control  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package reset_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_DB     = 3'd1,
    ASSERT       = 3'd2,
    RELEASE_WAIT = 3'd3,
    RELEASE_DB   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +----------------------------------------------------------------------------+
// | sync_2ff: generic 1-bit multi-flop synchronizer with selectable reset value |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_2ff
  import reset_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_button_ctrl.sv
// +----------------------------------------------------------------------------+
// | reset_button_ctrl: debounces the reset pushbutton into a clean, minimum-   |
// | width reset request. Revision: 1.0                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module reset_button_ctrl
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 64
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic btn_reset_n,
  output logic reset_req,
  output logic busy
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("reset_button_ctrl: DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_button_ctrl: HOLD_CYCLES must be >= 1");
  end

  logic             btn_sync;
  logic             pressed;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reset_req_q, reset_req_d;
  logic             busy_q, busy_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_btn_sync (
    .clk   (clk),
    .rst_n (async_reset_n),
    .d_i   (btn_reset_n),
    .q_o   (btn_sync)
  );

  assign pressed = ~btn_sync;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reset_req_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_req_q <= reset_req_d;
      busy_q      <= busy_d;
    end
  end

  // Every transition clears the counter; the button condition is tested
  // before the limit so a bounce always restarts the debounce window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = pressed ? RELEASE_WAIT : RELEASE_DB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!pressed) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they register glitch-free with it;
  // reset_req feeds an asynchronous preset downstream.
  always_comb begin
    reset_req_d = (state_d == ASSERT) || (state_d == RELEASE_WAIT) || (state_d == RELEASE_DB);
    busy_d      = (state_d != IDLE);
  end

  assign reset_req = reset_req_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_button_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_reset_button_ctrl: directed self-checking bench, DEBOUNCE=4, HOLD=8     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reset_button_ctrl;

  logic clk;
  logic async_reset_n;
  logic btn_reset_n;
  logic reset_req;
  logic busy;

  int checks;
  int errors;

  reset_button_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .btn_reset_n   (btn_reset_n),
    .reset_req     (reset_req),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    async_reset_n = 1'b0;
    btn_reset_n   = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      checks++;
      if (reset_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold edge %0d got req=%b busy=%b exp req=0 busy=0", e, reset_req, busy);
      end
    end
    async_reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      checks++;
      if (reset_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle edge %0d got req=%b busy=%b exp req=0 busy=0", e, reset_req, busy);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_req, exp_busy;
    btn_reset_n = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      exp_req  = (e >= 7) && (e < 36);
      exp_busy = (e >= 3) && (e < 36);
      checks++;
      if (reset_req !== exp_req) begin
        errors++;
        $display("FAIL clean_press_req edge %0d got %b exp %b", e, reset_req, exp_req);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL clean_press_busy edge %0d got %b exp %b", e, busy, exp_busy);
      end
      if (e == 29) btn_reset_n = 1'b1;
    end
  endtask

  task automatic test_bounce_reject();
    logic exp_busy;
    btn_reset_n = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      exp_busy = (e >= 3) && (e < 6);
      checks++;
      if (reset_req !== 1'b0) begin
        errors++;
        $display("FAIL bounce_req edge %0d got %b exp 0", e, reset_req);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL bounce_busy edge %0d got %b exp %b", e, busy, exp_busy);
      end
      if (e == 3) btn_reset_n = 1'b1;
    end
  endtask

  task automatic test_short_press();
    logic exp_req, exp_busy;
    btn_reset_n = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      exp_req  = (e >= 7) && (e < 19);
      exp_busy = (e >= 3) && (e < 19);
      checks++;
      if (reset_req !== exp_req) begin
        errors++;
        $display("FAIL short_press_req edge %0d got %b exp %b", e, reset_req, exp_req);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL short_press_busy edge %0d got %b exp %b", e, busy, exp_busy);
      end
      if (e == 6) btn_reset_n = 1'b1;
    end
  endtask

  task automatic test_release_chatter();
    logic exp_req, exp_busy;
    btn_reset_n = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      exp_req  = (e >= 7) && (e < 40);
      exp_busy = (e >= 3) && (e < 40);
      checks++;
      if (reset_req !== exp_req) begin
        errors++;
        $display("FAIL chatter_req edge %0d got %b exp %b", e, reset_req, exp_req);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL chatter_busy edge %0d got %b exp %b", e, busy, exp_busy);
      end
      if (e == 29) btn_reset_n = 1'b1;
      if (e == 32) btn_reset_n = 1'b0;
      if (e == 33) btn_reset_n = 1'b1;
    end
  endtask

  task automatic test_reset_mid_assert();
    btn_reset_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (reset_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_assert_pre got req=%b busy=%b exp req=1 busy=1", reset_req, busy);
    end
    #3;
    async_reset_n = 1'b0;
    #1;
    checks++;
    if (reset_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_assert_async got req=%b busy=%b exp req=0 busy=0", reset_req, busy);
    end
    btn_reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
    end
    async_reset_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      checks++;
      if (reset_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_assert_after edge %0d got req=%b busy=%b exp req=0 busy=0", e, reset_req, busy);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    async_reset_n = 1'b0;
    btn_reset_n   = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_short_press();
    test_release_chatter();
    test_reset_mid_assert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reset_button_ctrl.md
# reset_button_ctrl

Reset request controller ahead of `porf_gen`: synchronizes and debounces the board reset pushbutton and emits a clean, minimum-width, active-high `reset_req`. Top level ORs `reset_req` with `~async_reset_n` to form the `async_reset` input of `porf_gen`, whose chain then produces the stretched `sync_reset` for the 6502 core. Pressing the button must never generate runt or chattering reset pulses.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable samples required to accept a press or a release. Must be ≥1.
- `HOLD_CYCLES`, default 64: minimum cycles `reset_req` stays high before release tracking begins. Must be ≥1.
- `CNT_W`, default `$clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES)+1)`: counter width, derived, not overridden.

- `clk`  in  1  system clock
- `async_reset_n`  in  1  asynchronous, active-low reset (power-on / rail)
- `btn_reset_n`  in  1  raw pushbutton, active low, asynchronous to `clk`
- `reset_req`  out  1  debounced reset request, active high, registered
- `busy`  out  1  high whenever state ≠ IDLE, registered

## Operation
- `btn_reset_n` passes through a 2-flop synchronizer (both flops reset to 1). `pressed = ~btn_sync`.
- Single shared counter `cnt`, cleared on every state entry.
- States and transitions, evaluated each `clk` edge:
  - IDLE: `reset_req`=0. On `pressed` → PRESS_DB.
  - PRESS_DB: On `!pressed` → IDLE (bounce rejected). On `cnt==DEBOUNCE_CYCLES-1` with `pressed` → ASSERT. Otherwise `cnt++`.
  - ASSERT: `reset_req`=1. On `cnt==HOLD_CYCLES-1`: → RELEASE_DB if `!pressed`, else → RELEASE_WAIT. Otherwise `cnt++`. Button state is ignored until the hold expires.
  - RELEASE_WAIT: `reset_req`=1. On `!pressed` → RELEASE_DB.
  - RELEASE_DB: `reset_req`=1. On `pressed` → RELEASE_WAIT (bounce). On `cnt==DEBOUNCE_CYCLES-1` with `!pressed` → IDLE. Otherwise `cnt++`.
- `reset_req` and `busy` are flops loaded from next-state decode, so they are glitch-free. This is required because `reset_req` drives an asynchronous preset.
- Counter never wraps: it is compared against its limit and cleared on transition.
- Unused state encodings → IDLE.

## Timing
- Reset (`async_reset_n`=0, takes effect immediately, mid-operation included): state IDLE, `cnt`=0, sync flops 1, `reset_req`=0, `busy`=0.
- Press latency: pin low before edge 1 and held → `reset_req` high after edge `DEBOUNCE_CYCLES+3` (2 sync + 1 IDLE→PRESS_DB + DEBOUNCE_CYCLES).
- Release latency: pin high before edge r, with hold already expired → `reset_req` low after edge `r+2+DEBOUNCE_CYCLES`.
- Minimum `reset_req` width is `HOLD_CYCLES+DEBOUNCE_CYCLES` cycles, for any press that was accepted.
- Press shorter than `DEBOUNCE_CYCLES` consecutive synchronized samples: no `reset_req` pulse.
- A press edge and a counter-limit hit in the same cycle: the button condition wins in the DB states, per the transitions above.

## Structure
- Shared package `reset_pkg`: state encoding localparams (IDLE, PRESS_DB, ASSERT, RELEASE_WAIT, RELEASE_DB; 3-bit) and the `SYNC_STAGES`=2 constant.
- One sub-module: `sync_2ff` (generic 1-bit two-flop synchronizer, reset value parameterized, async active-low reset). It is reused later by other async inputs such as IRQ and NMI pins.
- FSM, counter and output registers live in `reset_button_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `HOLD_CYCLES`=8.
1. Hold `async_reset_n`=0 for 5 cycles, then release with button idle high for 20 cycles → `reset_req`=0 and `busy`=0 throughout.
2. Clean press: button low before edge 1, released before edge 30 → `reset_req` rises after edge 7 and falls after edge 36; `busy` rises after edge 3 and falls after edge 36.
3. Bounce reject: button low for 3 cycles, then high → `reset_req` never asserts; `busy` pulses and returns to 0 with state IDLE.
4. Short press: button released on the edge `reset_req` rises (edge 7) → `reset_req` stays high exactly 12 cycles, falling after edge 19.
5. Release chatter: during RELEASE_DB, button low for 1 cycle and then high → `reset_req` stays high; debounce restarts, and the fall occurs 4 cycles after the last synchronized release plus the return to RELEASE_DB.
6. Reset mid-ASSERT: drive `async_reset_n` low between edges while `reset_req`=1 → `reset_req` and `busy` go 0 asynchronously. After release with button high, the block stays in IDLE.
